// File: rtl/mxint_circular_buffer.sv
// mxint_circular_buffer
// Captures BUFFER_SIZE MXINT beats (IN_NUM mantissas + one shared exponent)
// and replays them in order REPEAT times on a valid/ready stream, then refills.
//
// Optional feature macro: MXINT_CIRCULAR_OVERLAP_EN
//   When defined, the next fill may start during the final replay pass. A slot
//   is rewritten only after its last read in that pass.
//   When undefined, inputs are refused for the whole replay phase.
//
// Handshake semantics (both ports): a beat transfers on a rising clk edge where
// valid && ready. The producer holds valid and data stable until the transfer.
// data_out_valid never drops mid-replay, and data_in_ready/data_out_valid
// depend only on registered state, never on the opposite side's valid/ready.
module mxint_circular_buffer #(
    parameter int DATA_PRECISION_0 = 16,
    parameter int DATA_PRECISION_1 = 8,
    parameter int IN_NUM           = 1,
    parameter int REPEAT           = 8,
    parameter int BUFFER_SIZE      = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_PRECISION_0-1:0] mdata_in [IN_NUM],
    input  logic [DATA_PRECISION_1-1:0] edata_in,
    input  logic                        data_in_valid,
    output logic                        data_in_ready,
    output logic [DATA_PRECISION_0-1:0] mdata_out [IN_NUM],
    output logic [DATA_PRECISION_1-1:0] edata_out,
    output logic                        data_out_valid,
    input  logic                        data_out_ready,
    output logic                        state_dbg_o
);

    localparam int PTR_W  = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;
    localparam int PASS_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;

    localparam logic [PTR_W-1:0]  LAST_SLOT = PTR_W'(BUFFER_SIZE - 1);
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
    localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(REPEAT - 1);
    localparam logic [PASS_W-1:0] PASS_ONE  = PASS_W'(1);

    typedef enum logic {
        FILL   = 1'b0,
        REPLAY = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PASS_W-1:0]   pass_cnt_q, pass_cnt_d;
`ifdef MXINT_CIRCULAR_OVERLAP_EN
    // Set once every slot has been rewritten during the final pass.
    logic                refilled_q, refilled_d;
`endif

    logic [DATA_PRECISION_0-1:0] mant_q [BUFFER_SIZE][IN_NUM];
    logic [DATA_PRECISION_1-1:0] exp_q  [BUFFER_SIZE];

    logic in_hs;
    logic out_hs;

    assign in_hs       = data_in_valid && data_in_ready;
    assign out_hs      = data_out_valid && data_out_ready;
    assign state_dbg_o = state_q;

    // Stream handshake outputs, derived only from registered state.
    always_comb begin
        data_in_ready  = 1'b0;
        data_out_valid = 1'b0;
        case (state_q)
            FILL: begin
                data_in_ready = 1'b1;
            end
            REPLAY: begin
                data_out_valid = 1'b1;
`ifdef MXINT_CIRCULAR_OVERLAP_EN
                // Only slots already read in the final pass may be rewritten.
                data_in_ready = (pass_cnt_q == LAST_PASS) && !refilled_q &&
                                (wr_ptr_q < rd_ptr_q);
`endif
            end
            default: begin
                data_in_ready  = 1'b0;
                data_out_valid = 1'b0;
            end
        endcase
    end

    // Output beat is read straight from storage at the replay pointer.
    always_comb begin
        for (int l = 0; l < IN_NUM; l++) begin
            mdata_out[l] = mant_q[rd_ptr_q][l];
        end
        edata_out = exp_q[rd_ptr_q];
    end

    // Next-state logic for the FSM, pointers and pass counter.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        pass_cnt_d = pass_cnt_q;
`ifdef MXINT_CIRCULAR_OVERLAP_EN
        refilled_d = refilled_q;
`endif

        // Write side: the last slot of a fill wraps the pointer.
        if (in_hs) begin
            if (wr_ptr_q == LAST_SLOT) begin
                wr_ptr_d = '0;
                if (state_q == FILL) begin
                    state_d = REPLAY;
                end
`ifdef MXINT_CIRCULAR_OVERLAP_EN
                else begin
                    refilled_d = 1'b1;
                end
`endif
            end else begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
        end

        // Read side: the last slot ends a pass; the last pass ends the replay.
        if (out_hs) begin
            if (rd_ptr_q == LAST_SLOT) begin
                rd_ptr_d = '0;
                if (pass_cnt_q == LAST_PASS) begin
                    pass_cnt_d = '0;
`ifdef MXINT_CIRCULAR_OVERLAP_EN
                    state_d    = refilled_q ? REPLAY : FILL;
                    refilled_d = 1'b0;
`else
                    state_d    = FILL;
`endif
                end else begin
                    pass_cnt_d = pass_cnt_q + PASS_ONE;
                end
            end else begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
        end
    end

    // Control registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FILL;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pass_cnt_q <= '0;
`ifdef MXINT_CIRCULAR_OVERLAP_EN
            refilled_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pass_cnt_q <= pass_cnt_d;
`ifdef MXINT_CIRCULAR_OVERLAP_EN
            refilled_q <= refilled_d;
`endif
        end
    end

    // Beat storage: cleared on reset, written on each accepted input beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < BUFFER_SIZE; s++) begin
                exp_q[s] <= '0;
                for (int l = 0; l < IN_NUM; l++) begin
                    mant_q[s][l] <= '0;
                end
            end
        end else if (in_hs) begin
            exp_q[wr_ptr_q] <= edata_in;
            for (int l = 0; l < IN_NUM; l++) begin
                mant_q[wr_ptr_q][l] <= mdata_in[l];
            end
        end
    end

endmodule
